// File: rtl/bram32_arbiter_pkg.sv
// Shared types and constants for the bram32 two-master arbiter.
// Holds the FSM state encoding and the master index values.
package bram32_arbiter_pkg;

    localparam int ADR_W = 16;
    localparam int DAT_W = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/bram32_arbiter_if.sv
// One master's request port into the bram32 arbiter.
// Handshake: master raises req with stable we/adr/dat_w and holds it until ack;
// ack is a single-cycle pulse, and dat_r carries read data in that same cycle.
interface bram32_arbiter_if;
    import bram32_arbiter_pkg::*;

    logic             req;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [DAT_W-1:0] dat_r;
    logic             ack;

    modport master (output req, output we, output adr, output dat_w,
                    input dat_r, input ack);
    modport slave  (input req, input we, input adr, input dat_w,
                    output dat_r, output ack);
endinterface

// File: rtl/bram32.sv
// Single-port 32-bit word RAM with a one-cycle registered read.
// Decodes byte address bits [adr_width-1:2]; higher bits alias.
module bram32 #(
    parameter int adr_width = 11
) (
    input  logic        sys_clk,
    input  logic [15:0] a,
    input  logic        we,
    input  logic [31:0] dat_w,
    output logic [31:0] dat_r
);

    logic [31:0]          mem [0:(1 << (adr_width - 2)) - 1];
    logic [adr_width-3:0] idx;
    logic                 unused_adr;

    assign idx        = a[adr_width-1:2];
    assign unused_adr = ^{a[15:adr_width], a[1:0]};

    always_ff @(posedge sys_clk) begin
        if (we) mem[idx] <= dat_w;
        dat_r <= mem[idx];
    end

endmodule

// File: rtl/bram32_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone request wins,
// a tie goes to the master named by ptr.
module rr_arb2
    import bram32_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | (ptr == M0));
    assign gnt[1] = req[1] & (~req[0] | (ptr == M1));

endmodule

// File: rtl/bram32_arbiter.sv
// Shares one bram32 between two masters with round-robin arbitration.
// All outputs, including the RAM port, are registered.
module bram32_arbiter
    import bram32_arbiter_pkg::*;
#(
    parameter int adr_width = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    bram32_arbiter_if.slave  m0,
    bram32_arbiter_if.slave  m1,
    output logic [ADR_W-1:0] bram_a,
    output logic             bram_we,
    output logic [DAT_W-1:0] bram_do,
    input  logic [DAT_W-1:0] bram_di,
    output logic             busy,
    output state_t           state_dbg
);

    if (adr_width < 3 || adr_width > 15) begin : g_bad_adr_width
        $error("bram32_arbiter: adr_width out of supported range");
    end

    state_t           state, state_nxt;
    logic             win, win_nxt;
    logic             ptr, ptr_nxt;
    logic             cur_we;
    logic             load;
    logic [1:0]       req, gnt;
    logic             sel_we;
    logic [ADR_W-1:0] sel_adr;
    logic [DAT_W-1:0] sel_dat;

    assign req       = {m1.req, m0.req};
    assign state_dbg = state;

    rr_arb2 u_rr_arb2 (
        .req (req),
        .ptr (ptr),
        .gnt (gnt)
    );

    // RESP hands the port straight to the other master if it is waiting;
    // the winner's own req is not looked at until IDLE.
    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        ptr_nxt   = ptr;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|gnt) begin
                    load      = 1'b1;
                    win_nxt   = gnt[1] ? M1 : M0;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP: begin
                ptr_nxt = ~win;
                if (req[~win]) begin
                    load      = 1'b1;
                    win_nxt   = ~win;
                    state_nxt = ST_ACCESS;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sel_we  = (win_nxt == M1) ? m1.we    : m0.we;
    assign sel_adr = (win_nxt == M1) ? m1.adr   : m0.adr;
    assign sel_dat = (win_nxt == M1) ? m1.dat_w : m0.dat_w;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= ST_IDLE;
            win      <= M0;
            ptr      <= M0;
            cur_we   <= 1'b0;
            bram_a   <= '0;
            bram_we  <= 1'b0;
            bram_do  <= '0;
            busy     <= 1'b0;
            m0.ack   <= 1'b0;
            m1.ack   <= 1'b0;
            m0.dat_r <= '0;
            m1.dat_r <= '0;
        end else begin
            state  <= state_nxt;
            win    <= win_nxt;
            ptr    <= ptr_nxt;
            busy   <= (state_nxt != ST_IDLE);
            m0.ack <= (state == ST_RESP) && (win == M0);
            m1.ack <= (state == ST_RESP) && (win == M1);
            if (state == ST_RESP && !cur_we && win == M0) m0.dat_r <= bram_di;
            if (state == ST_RESP && !cur_we && win == M1) m1.dat_r <= bram_di;
            if (load) begin
                bram_a  <= sel_adr;
                bram_we <= sel_we;
                bram_do <= sel_dat;
                cur_we  <= sel_we;
            end else begin
                bram_we <= 1'b0;
            end
        end
    end

endmodule
